axis_moving_average: RTL and testbench
======================================

Name: axis_moving_average

Overview:
Streaming boxcar (moving-average) smoother placed directly downstream of the sample-and-hold interpolator, ahead of the DAC interface. It removes the staircase produced by repeated held samples. Each output is the mean of the last 2^cfg_data signed input samples. It is a single-register AXI4-Stream stage with full backpressure.

Parameters:
AXIS_TDATA_WIDTH, 16, signed sample width (two's complement) on both slave and master sides
MAX_LOG2, 4, log2 of maximum window depth; delay line holds 2^MAX_LOG2 samples
CFG_WIDTH, 8, width of cfg_data

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  synchronous, active-low reset
cfg_data  input  CFG_WIDTH  log2 of window length L; effective value k = min(cfg_data, MAX_LOG2)
s_axis_tready  output  1  input accept
s_axis_tdata  input  AXIS_TDATA_WIDTH  input sample, signed
s_axis_tvalid  input  1  input valid
m_axis_tready  input  1  downstream accept
m_axis_tdata  output  AXIS_TDATA_WIDTH  averaged sample, signed
m_axis_tvalid  output  1  output valid

Behaviour:
- Reset (aresetn low at posedge): m_axis_tvalid=0, m_axis_tdata=0, accumulator=0, all delay-line entries=0, write pointer=0, registered cfg = current k. s_axis_tready is 0 while aresetn is low.
- State: accumulator ACC of width AXIS_TDATA_WIDTH+MAX_LOG2, signed. Circular delay line BUF[0..2^MAX_LOG2-1]. Write pointer WP of MAX_LOG2 bits, wraps modulo depth.
- s_axis_tready = aresetn & ~flush & (~m_axis_tvalid | m_axis_tready). The combinational path from m_axis_tready is permitted.
- Input accept (s_axis_tvalid & s_axis_tready), with N = 2^k:
  - old = BUF[(WP - N) mod depth], read before write. When N = depth, this is BUF[WP].
  - ACC <= ACC + sext(x) - sext(old).
  - BUF[WP] <= x; WP <= WP+1.
  - m_axis_tdata <= (ACC + x - old) >>> k, arithmetic shift; truncation toward -inf unless the optional feature below is enabled.
  - m_axis_tvalid <= 1.
- Latency: output valid the cycle after acceptance. Throughput is one sample per clock under continuous valid/ready.
- Output consumed with no new accept (m_axis_tvalid & m_axis_tready & ~accept): m_axis_tvalid <= 0. m_axis_tdata holds its last value.
- Simultaneous consume and accept: m_axis_tvalid stays 1 and the new value replaces the old. No bubble.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata is stable and no input is accepted.
- No overflow is possible: |ACC| ≤ 2^MAX_LOG2·2^(W-1), which fits W+MAX_LOG2 bits. The result after >>>k always fits W bits.
- Warm-up: the delay line starts at zero, so the first N-1 outputs average against zeros. There is no special-casing.
- Window change: flush is a combinational compare, asserted when the registered k ≠ the clamped cfg_data.
  - In the flush cycle: ACC, BUF and WP are cleared, the registered k is updated, and s_axis_tready=0.
  - The pending output register (m_axis_tvalid/m_axis_tdata) is untouched and drains normally.
- k=0 (N=1): old = BUF[WP-1], the previous sample, so the output equals the input (pass-through with 1-cycle latency).
- cfg_data > MAX_LOG2: clamped to MAX_LOG2.
- Reset mid-stream: any valid output is dropped; the delay line and ACC are zeroed.

Optional Feature:
- Macro AXIS_MOVING_AVERAGE_ROUND_EN.
- Defined: the output is (sum + (k>0 ? 2^(k-1) : 0)) >>> k, i.e. round-half-up. The rounding add uses one extra guard bit so it cannot wrap.
- Undefined: plain arithmetic-shift truncation, as above. Port list and latency are identical in both builds.

Test Plan:
- Pass-through: k=0, inputs 5, -3, 100, m_axis_tready=1 -> outputs 5, -3, 100, each 1 cycle after accept.
- Warm-up and steady state: k=2, inputs 4,4,4,4,4 -> outputs 1,2,3,4,4. Then inputs 8,8,8,8 -> outputs 5,6,7,8.
- Staircase smoothing: k=2, input 0,0,0,0,16,16,16,16 -> outputs 0,0,0,0,4,8,12,16.
- Rounding: k=1, inputs 0 then 3 (sum 3) -> output 1 truncated, 2 with ROUND_EN. Inputs 0 then -3 -> output -2 truncated, -1 with ROUND_EN.
- Backpressure: continuous valid, m_axis_tready toggled 1,0,0,1 -> no sample lost or duplicated, m_axis_tdata stable while stalled, s_axis_tready=0 during stall.
- Window change and reset: at steady state of 16 with k=2, set cfg_data=3 -> one cycle with s_axis_tready=0, next input 16 gives output 2. Full-scale -32768 ×16 at k=4 -> output -32768. Pulse aresetn mid-stream -> m_axis_tvalid=0 next cycle, next input restarts from zeroed history.

Source files
------------

// File: rtl/axis_moving_average.sv
// Streaming boxcar smoother: each output is the mean of the last 2^k signed samples.
// Optional round-half-up output enabled by defining AXIS_MOVING_AVERAGE_ROUND_EN.
module axis_moving_average #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int MAX_LOG2         = 4,
  parameter int CFG_WIDTH        = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CFG_WIDTH-1:0]        cfg_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  localparam int W     = AXIS_TDATA_WIDTH;
  localparam int AW    = AXIS_TDATA_WIDTH + MAX_LOG2;
  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int KW    = $clog2(MAX_LOG2 + 1);

  logic [KW-1:0]        k_clamp, k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [MAX_LOG2-1:0]  wp_q, wp_d, rd_idx;
  logic signed [W-1:0]  buf_q [DEPTH];
  logic signed [W-1:0]  buf_d [DEPTH];
  logic signed [W-1:0]  mdata_q, mdata_d, x, old, avg;
  logic                 mvalid_q, mvalid_d, flush, accept;

  always_comb begin
    if (cfg_data > CFG_WIDTH'(MAX_LOG2)) k_clamp = KW'(MAX_LOG2);
    else                                 k_clamp = cfg_data[KW-1:0];
  end

  assign flush         = (k_q != k_clamp);
  assign s_axis_tready = aresetn & ~flush & (~mvalid_q | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // With N = depth the shifted one wraps to zero, so the oldest entry is BUF[WP].
  always_comb begin
    x      = s_axis_tdata;
    rd_idx = wp_q - (MAX_LOG2'(1) << k_q);
    old    = buf_q[rd_idx];
    sum    = acc_q + AW'(x) - AW'(old);
  end

`ifdef AXIS_MOVING_AVERAGE_ROUND_EN
  logic signed [AW:0] bias;

  always_comb begin
    bias = '0;
    if (k_q != '0) bias[k_q - KW'(1)] = 1'b1;
    avg = W'(((AW+1)'(sum) + bias) >>> k_q);
  end
`else
  always_comb begin
    avg = W'(sum >>> k_q);
  end
`endif

  always_comb begin
    k_d      = k_q;
    acc_d    = acc_q;
    wp_d     = wp_q;
    buf_d    = buf_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;

    if (flush) begin
      k_d   = k_clamp;
      acc_d = '0;
      wp_d  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) buf_d[i] = '0;
    end else if (accept) begin
      acc_d       = sum;
      buf_d[wp_q] = x;
      wp_d        = wp_q + MAX_LOG2'(1);
    end

    // Output register drains independently of a flush.
    if (accept) begin
      mvalid_d = 1'b1;
      mdata_d  = avg;
    end else if (mvalid_q && m_axis_tready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      k_q      <= k_clamp;
      acc_q    <= '0;
      wp_q     <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      k_q      <= k_d;
      acc_q    <= acc_d;
      wp_q     <= wp_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;

endmodule

// File: tb/tb_axis_moving_average.sv
// Scoreboard bench for axis_moving_average: a reference model averages the sample history
// and queues expected outputs; an independent monitor checks every output transfer.
module tb_axis_moving_average;

  localparam int W  = 16;
  localparam int ML = 4;
  localparam int CW = 8;
`ifdef AXIS_MOVING_AVERAGE_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b1;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int seen[$];
  int hist[$];
  int mk = 0;
  int rdy_mode = 0;
  int pi = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  always #5 aclk = ~aclk;

  axis_moving_average #(
    .AXIS_TDATA_WIDTH(W),
    .MAX_LOG2(ML),
    .CFG_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cfg_data(cfg_data),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid)
  );

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  function automatic int clampk(int c);
    return (c > ML) ? ML : c;
  endfunction

  // Mean of the last 2^k accepted samples (missing history counts as zero), floor or round-half-up.
  function automatic int model_out(int k);
    longint s = 0;
    longint q;
    int n = 1 << k;
    for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
    if (RND != 0 && k > 0) s += n / 2;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  // Reference model: tracks window setting, history and expected outputs.
  always @(negedge aclk) begin
    int ck;
    bit er;
    ck = clampk(int'(cfg_data));
    if (!aresetn) begin
      hist.delete();
      exp_q.delete();
      mk = ck;
      check("rst_tready", int'(s_axis_tready), 0);
    end else begin
      er = (mk == ck) && (!m_axis_tvalid || m_axis_tready);
      check("s_tready", int'(s_axis_tready), int'(er));
      if (mk != ck) begin
        hist.delete();
        mk = ck;
      end else if (s_axis_tvalid && er) begin
        hist.push_back(int'($signed(s_axis_tdata)));
        if (hist.size() > (1 << ML)) void'(hist.pop_front());
        exp_q.push_back(model_out(mk));
      end
    end
  end

  // Monitor: compares each output transfer and checks stability under backpressure.
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", int'(m_axis_tvalid), 1);
        check("stall_stable", int'($signed(m_axis_tdata)), int'($signed(stall_data)));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("unexpected_out", int'(m_axis_tvalid), 0);
        else check("data", int'($signed(m_axis_tdata)), exp_q.pop_front());
        seen.push_back(int'($signed(m_axis_tdata)));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
    end
  end

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      2: begin
        m_axis_tready = pat[pi % 4];
        pi++;
      end
      default: m_axis_tready = 1'b1;
    endcase
  end

  task automatic send(int x);
    bit done = 1'b0;
    s_axis_tdata  = W'(x);
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge aclk);
      done = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!done) timeout("send_timeout");
  endtask

  task automatic idle(int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge aclk);
      #1;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  task automatic expect_seq(string nm, int e[$]);
    check({nm, "_count"}, seen.size(), e.size());
    for (int i = 0; i < e.size() && i < seen.size(); i++) check(nm, seen[i], e[i]);
  endtask

  initial begin
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_valid", int'(m_axis_tvalid), 0);
    check("rst_data", int'(m_axis_tdata), 0);
    aresetn = 1'b1;

    seen.delete();
    send(5); send(-3); send(100);
    drain();
    expect_seq("pass_through", '{5, -3, 100});

    cfg_data = 2;
    seen.delete();
    repeat (5) send(4);
    drain();
    expect_seq("warmup", '{1, 2, 3, 4, 4});
    seen.delete();
    repeat (4) send(8);
    drain();
    expect_seq("steady", '{5, 6, 7, 8});

    cfg_data = 1; idle(2);
    cfg_data = 2; idle(2);
    seen.delete();
    repeat (4) send(0);
    repeat (4) send(16);
    drain();
    expect_seq("staircase", '{0, 0, 0, 0, 4, 8, 12, 16});

    cfg_data = 3;
    @(negedge aclk);
    check("flush_tready", int'(s_axis_tready), 0);
    @(posedge aclk); #1;
    seen.delete();
    send(16);
    drain();
    expect_seq("window_change", '{2});

    cfg_data = 1;
    seen.delete();
    send(0); send(3); send(0); send(-3);
    drain();
    if (RND != 0) expect_seq("round", '{0, 2, 2, -1});
    else          expect_seq("trunc", '{0, 1, 1, -2});

    cfg_data = 4;
    seen.delete();
    repeat (16) send(-32768);
    drain();
    check("fullscale_count", seen.size(), 16);
    if (seen.size() == 16) begin
      check("fullscale_first", seen[0], -2048);
      check("fullscale_last", seen[15], -32768);
    end
    cfg_data = 200;
    @(negedge aclk);
    check("clamp_no_flush", int'(s_axis_tready), 1);
    @(posedge aclk); #1;
    seen.delete();
    send(-32768);
    drain();
    expect_seq("clamp", '{-32768});

    cfg_data = 2;
    pi = 0;
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) send(int'($signed(W'($urandom))));
    rdy_mode = 0;
    drain();

    send(7); send(9);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("rst_mid_valid", int'(m_axis_tvalid), 0);
    aresetn = 1'b1;
    seen.delete();
    send(40);
    drain();
    expect_seq("after_reset", '{10});

    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) cfg_data = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send(int'($signed(W'($urandom))));
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1);
  end

endmodule
